// File: rtl/adxl345_sample_assembler.sv
// rtl/adxl345_sample_assembler.sv - assembles ADXL345 DATAX0..DATAZ1 bytes into averaged axis samples
module adxl345_sample_assembler #(
    parameter int                 AVG_LOG2 = 2,
    parameter logic signed [15:0] DEADBAND = 16'sd64
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    input  logic        frame_abort,
    output logic        sample_valid,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic [3:0]  tilt,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic        busy
);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DRAIN   = 1'b1
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'((1 << AVG_LOG2) - 1);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shadow_q [5];
    logic [7:0]         shadow_d [5];
    logic signed [18:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_z_q, acc_z_d;
    logic [2:0]         frm_cnt_q, frm_cnt_d;
    logic [15:0]        accel_x_q, accel_x_d, accel_y_q, accel_y_d, accel_z_q, accel_z_d;
    logic [3:0]         tilt_q, tilt_d;
    logic               sample_valid_q, sample_valid_d;
    logic               frame_err_q, frame_err_d;
    logic [7:0]         err_count_q, err_count_d;

    logic signed [18:0] sum_x, sum_y, sum_z;
    logic [15:0]        new_x, new_y, new_z;
    logic               frame_done, frame_bad;

    function automatic logic [15:0] avg_out(input logic signed [18:0] s);
        logic signed [18:0] sh;
        sh = s >>> AVG_LOG2;
        return sh[15:0];
    endfunction

    function automatic logic [1:0] tilt_of(input logic [15:0] v);
        logic signed [15:0] s;
        s = v;
        return {s > DEADBAND, s < -DEADBAND};
    endfunction

    // Z1 arrives on the completing cycle, so Z is formed straight from byte_data.
    always_comb begin
        sum_x = acc_x_q + {{3{shadow_q[1][7]}}, shadow_q[1], shadow_q[0]};
        sum_y = acc_y_q + {{3{shadow_q[3][7]}}, shadow_q[3], shadow_q[2]};
        sum_z = acc_z_q + {{3{byte_data[7]}}, byte_data, shadow_q[4]};
        new_x = avg_out(sum_x);
        new_y = avg_out(sum_y);
        new_z = avg_out(sum_z);
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        shadow_d       = shadow_q;
        acc_x_d        = acc_x_q;
        acc_y_d        = acc_y_q;
        acc_z_d        = acc_z_q;
        frm_cnt_d      = frm_cnt_q;
        accel_x_d      = accel_x_q;
        accel_y_d      = accel_y_q;
        accel_z_d      = accel_z_q;
        tilt_d         = tilt_q;
        sample_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        err_count_d    = err_count_q;
        frame_done     = 1'b0;
        frame_bad      = 1'b0;

        if (frame_abort) begin
            frame_bad = (idx_q != 3'd0) || (state_q == ST_DRAIN);
            idx_d     = 3'd0;
            state_d   = ST_COLLECT;
        end else if (byte_valid) begin
            if (state_q == ST_DRAIN) begin
                if (byte_last) begin
                    state_d = ST_COLLECT;
                    idx_d   = 3'd0;
                end
            end else begin
                case (idx_q)
                    3'd0:    shadow_d[0] = byte_data;
                    3'd1:    shadow_d[1] = byte_data;
                    3'd2:    shadow_d[2] = byte_data;
                    3'd3:    shadow_d[3] = byte_data;
                    3'd4:    shadow_d[4] = byte_data;
                    default: ;
                endcase
                if (idx_q == 3'd5) begin
                    idx_d = 3'd0;
                    if (byte_last) begin
                        frame_done = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = ST_DRAIN;
                    end
                end else if (byte_last) begin
                    frame_bad = 1'b1;
                    idx_d     = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
        end

        if (frame_done) begin
            if (frm_cnt_q == LAST_CNT) begin
                accel_x_d      = new_x;
                accel_y_d      = new_y;
                accel_z_d      = new_z;
                tilt_d         = {tilt_of(new_x), tilt_of(new_y)};
                sample_valid_d = 1'b1;
                acc_x_d        = '0;
                acc_y_d        = '0;
                acc_z_d        = '0;
                frm_cnt_d      = 3'd0;
            end else begin
                acc_x_d   = sum_x;
                acc_y_d   = sum_y;
                acc_z_d   = sum_z;
                frm_cnt_d = frm_cnt_q + 3'd1;
            end
        end

        if (frame_bad) begin
            frame_err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q        <= ST_COLLECT;
            idx_q          <= 3'd0;
            shadow_q       <= '{default: 8'd0};
            acc_x_q        <= '0;
            acc_y_q        <= '0;
            acc_z_q        <= '0;
            frm_cnt_q      <= 3'd0;
            accel_x_q      <= 16'd0;
            accel_y_q      <= 16'd0;
            accel_z_q      <= 16'd0;
            tilt_q         <= 4'd0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            err_count_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            acc_x_q        <= acc_x_d;
            acc_y_q        <= acc_y_d;
            acc_z_q        <= acc_z_d;
            frm_cnt_q      <= frm_cnt_d;
            accel_x_q      <= accel_x_d;
            accel_y_q      <= accel_y_d;
            accel_z_q      <= accel_z_d;
            tilt_q         <= tilt_d;
            sample_valid_q <= sample_valid_d;
            frame_err_q    <= frame_err_d;
            err_count_q    <= err_count_d;
        end
    end

    assign sample_valid = sample_valid_q;
    assign accel_x      = accel_x_q;
    assign accel_y      = accel_y_q;
    assign accel_z      = accel_z_q;
    assign tilt         = tilt_q;
    assign frame_err    = frame_err_q;
    assign err_count    = err_count_q;
    assign busy         = (idx_q != 3'd0) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_adxl345_sample_assembler.sv
// tb/tb_adxl345_sample_assembler.sv - randomized model-checked bench for adxl345_sample_assembler
module tb_adxl345_sample_assembler;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'd0;
    logic       byte_last = 1'b0;
    logic       frame_abort = 1'b0;

    logic        sv0, fe0, busy0, sv2, fe2, busy2;
    logic [15:0] ax0, ay0, az0, ax2, ay2, az2;
    logic [3:0]  tl0, tl2;
    logic [7:0]  ec0, ec2;

    always #5 CLOCK_50 = ~CLOCK_50;

    adxl345_sample_assembler #(.AVG_LOG2(0), .DEADBAND(16'sd64)) u_dut0 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_last(byte_last), .frame_abort(frame_abort), .sample_valid(sv0), .accel_x(ax0),
        .accel_y(ay0), .accel_z(az0), .tilt(tl0), .frame_err(fe0), .err_count(ec0), .busy(busy0)
    );

    adxl345_sample_assembler #(.AVG_LOG2(2), .DEADBAND(16'sd64)) u_dut2 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_last(byte_last), .frame_abort(frame_abort), .sample_valid(sv2), .accel_x(ax2),
        .accel_y(ay2), .accel_z(az2), .tilt(tl2), .frame_err(fe2), .err_count(ec2), .busy(busy2)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model: index 0 mirrors u_dut0 (1 frame/sample), index 1 mirrors u_dut2 (4 frames/sample).
    int          navg [2] = '{1, 4};
    logic [7:0]  frame_q [$];
    bit          draining;
    int          m_cnt [2];
    longint      m_sx [2], m_sy [2], m_sz [2];
    logic [15:0] e_x [2], e_y [2], e_z [2];
    logic [3:0]  e_tilt [2];
    bit          e_sv [2];
    bit          e_fe, e_busy, chk_en;
    int          e_errs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] floor_avg(input longint s, input int n);
        longint q;
        if (s >= 0) q = s / n;
        else        q = -((-s + n - 1) / n);
        return q[15:0];
    endfunction

    function automatic logic [1:0] tilt_pair(input logic [15:0] v);
        logic signed [15:0] t;
        int i;
        t = v;
        i = t;
        return {i > 64, i < -64};
    endfunction

    task automatic model_reset();
        frame_q.delete();
        draining = 0;
        e_fe = 0;
        e_busy = 0;
        e_errs = 0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_sx[k] = 0; m_sy[k] = 0; m_sz[k] = 0;
            e_x[k] = 0; e_y[k] = 0; e_z[k] = 0; e_tilt[k] = 0; e_sv[k] = 0;
        end
    endtask

    task automatic model_frame();
        logic signed [15:0] t;
        int x, y, z;
        t = {frame_q[1], frame_q[0]}; x = t;
        t = {frame_q[3], frame_q[2]}; y = t;
        t = {frame_q[5], frame_q[4]}; z = t;
        for (int k = 0; k < 2; k++) begin
            m_sx[k] += x; m_sy[k] += y; m_sz[k] += z;
            m_cnt[k]++;
            if (m_cnt[k] == navg[k]) begin
                e_x[k] = floor_avg(m_sx[k], navg[k]);
                e_y[k] = floor_avg(m_sy[k], navg[k]);
                e_z[k] = floor_avg(m_sz[k], navg[k]);
                e_tilt[k] = {tilt_pair(e_x[k]), tilt_pair(e_y[k])};
                e_sv[k] = 1;
                m_cnt[k] = 0; m_sx[k] = 0; m_sy[k] = 0; m_sz[k] = 0;
            end
        end
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit l, input bit a);
        e_sv[0] = 0;
        e_sv[1] = 0;
        e_fe = 0;
        if (a) begin
            if (frame_q.size() > 0 || draining) e_fe = 1;
            frame_q.delete();
            draining = 0;
        end else if (v) begin
            if (draining) begin
                if (l) draining = 0;
            end else begin
                frame_q.push_back(d);
                if (frame_q.size() == 6) begin
                    if (l) model_frame();
                    else begin
                        e_fe = 1;
                        draining = 1;
                    end
                    frame_q.delete();
                end else if (l) begin
                    e_fe = 1;
                    frame_q.delete();
                end
            end
        end
        if (e_fe) e_errs++;
        e_busy = (frame_q.size() > 0) || draining;
    endtask

    always @(posedge CLOCK_50) begin
        #1;
        if (chk_en) begin
            check("sv0", 32'(sv0), 32'(e_sv[0]));
            check("sv2", 32'(sv2), 32'(e_sv[1]));
            check("x0", 32'(ax0), 32'(e_x[0]));
            check("y0", 32'(ay0), 32'(e_y[0]));
            check("z0", 32'(az0), 32'(e_z[0]));
            check("tilt0", 32'(tl0), 32'(e_tilt[0]));
            check("x2", 32'(ax2), 32'(e_x[1]));
            check("y2", 32'(ay2), 32'(e_y[1]));
            check("z2", 32'(az2), 32'(e_z[1]));
            check("tilt2", 32'(tl2), 32'(e_tilt[1]));
            check("fe0", 32'(fe0), 32'(e_fe));
            check("fe2", 32'(fe2), 32'(e_fe));
            check("ec0", 32'(ec0), (e_errs > 255) ? 32'd255 : 32'(e_errs));
            check("ec2", 32'(ec2), (e_errs > 255) ? 32'd255 : 32'(e_errs));
            check("busy0", 32'(busy0), 32'(e_busy));
            check("busy2", 32'(busy2), 32'(e_busy));
        end
    end

    task automatic drive(input bit v, input logic [7:0] d, input bit l, input bit a);
        @(negedge CLOCK_50);
        byte_valid = v;
        byte_data = d;
        byte_last = l;
        frame_abort = a;
        model_step(v, d, l, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 8'd0, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge CLOCK_50);
        reset_n = 0;
        byte_valid = 0;
        byte_data = 0;
        byte_last = 0;
        frame_abort = 0;
        model_reset();
        chk_en = 1;
        @(negedge CLOCK_50);
        reset_n = 1;
        model_step(0, 8'd0, 0, 0);
    endtask

    task automatic send_frame(input int x, input int y, input int z);
        logic [15:0] ux, uy, uz;
        logic [7:0] b [6];
        ux = x[15:0]; uy = y[15:0]; uz = z[15:0];
        b = '{ux[7:0], ux[15:8], uy[7:0], uy[15:8], uz[7:0], uz[15:8]};
        for (int i = 0; i < 6; i++) drive(1, b[i], i == 5, 0);
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) drive(1, 8'($urandom), i == n - 1, 0);
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
    endtask

    function automatic int rand_axis();
        int bl [6];
        logic signed [15:0] t;
        bl = '{64, -64, 65, -65, 0, -32768};
        if ($urandom_range(0, 3) == 0) return bl[$urandom_range(0, 5)];
        t = 16'($urandom);
        return int'(t);
    endfunction

    initial begin
        chk_en = 0;
        model_reset();
        apply_reset();
        idle(2);

        send_frame(32'h1234, 32'hABCD, 32'h0100);
        @(posedge CLOCK_50); #2;
        lit("t1_sv", 32'(sv0), 32'd1);
        lit("t1_x", 32'(ax0), 32'h1234);
        lit("t1_y", 32'(ay0), 32'hABCD);
        lit("t1_z", 32'(az0), 32'h0100);
        lit("t1_tilt", 32'(tl0), 32'b1001);
        lit("t1_fe", 32'(fe0), 32'd0);
        idle(2);

        apply_reset();
        send_frame(-1, 0, 0);
        send_frame(-1, 0, 0);
        send_frame(-1, 0, 0);
        send_frame(0, 0, 0);
        @(posedge CLOCK_50); #2;
        lit("t2a_sv", 32'(sv2), 32'd1);
        lit("t2a_x", 32'(ax2), 32'hFFFF);
        lit("t2a_tilt", 32'(tl2), 32'd0);
        send_frame(100, 0, 0);
        send_frame(200, 0, 0);
        send_frame(-300, 0, 0);
        send_frame(400, 0, 0);
        @(posedge CLOCK_50); #2;
        lit("t2b_x", 32'(ax2), 32'd100);
        lit("t2b_tilt", 32'(tl2), 32'b1000);

        apply_reset();
        send_bytes(3);
        @(posedge CLOCK_50); #2;
        lit("t3_fe", 32'(fe2), 32'd1);
        lit("t3_ec", 32'(ec2), 32'd1);
        idle(1);
        send_frame(500, -500, 7);

        send_bytes(8);
        idle(1);
        send_frame(-70, 70, 1);

        drive(1, 8'h11, 0, 0);
        drive(1, 8'h22, 0, 1);
        @(posedge CLOCK_50); #2;
        lit("t5_fe", 32'(fe0), 32'd1);
        lit("t5_busy", 32'(busy0), 32'd0);
        drive(0, 8'd0, 0, 1);
        drive(1, 8'h33, 0, 1);
        send_frame(1, 2, 3);

        drive(1, 8'h44, 0, 0);
        drive(1, 8'h55, 0, 0);
        apply_reset();
        send_frame(10, 10, 10);
        send_frame(20, 20, 20);
        apply_reset();
        send_frame(1000, -8, 3);
        send_frame(2000, -8, 3);
        send_frame(3000, -8, 3);
        send_frame(4001, -9, 3);
        @(posedge CLOCK_50); #2;
        lit("t6_x", 32'(ax2), 32'd2500);
        lit("t6_y", 32'(ay2), 32'hFFF7);

        for (int i = 0; i < 300; i++) send_bytes(2);
        @(posedge CLOCK_50); #2;
        lit("t6_ec_sat", 32'(ec2), 32'd255);

        apply_reset();
        for (int i = 0; i < 400; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 6) send_frame(rand_axis(), rand_axis(), rand_axis());
            else if (kind == 6) send_bytes($urandom_range(1, 5));
            else if (kind == 7) send_bytes($urandom_range(7, 10));
            else if (kind == 8) begin
                send_bytes(0);
                for (int j = 0; j < $urandom_range(0, 5); j++) drive(1, 8'($urandom), 0, 0);
                drive($urandom_range(0, 1) == 1, 8'($urandom), 0, 1);
            end else drive(0, 8'd0, 0, 1);
            idle($urandom_range(0, 2));
        end
        idle(3);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adxl345_sample_assembler.md
Name: adxl345_sample_assembler

Overview:
- Downstream consumer of the I2C accelerometer read engine.
- Takes the DATAX0..DATAZ1 byte stream of the ADXL345 multi-byte read and assembles three signed 16-bit axis values.
- Optionally averages 2^AVG_LOG2 frames, derives a 4-bit tilt indication for LEDR/HEX display logic, and detects and counts malformed frames.

Parameters:
- AVG_LOG2, 2, log2 of frames averaged per output sample; legal range 0..3 (0 = no averaging).
- DEADBAND, 16'sd64, tilt threshold magnitude in raw LSBs (signed, positive).

Ports:
- CLOCK_50  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous reset, active-low.
- byte_valid  input  1  one received data byte present this cycle.
- byte_data  input  8  received byte.
- byte_last  input  1  qualifies byte_valid; final byte of the read (master NACKs and STOPs after it).
- frame_abort  input  1  I2C error (missing ACK, bus fault); discard any partial frame.
- sample_valid  output  1  one-cycle pulse; accel_x/y/z and tilt updated.
- accel_x  output  16  signed X, averaged.
- accel_y  output  16  signed Y, averaged.
- accel_z  output  16  signed Z, averaged.
- tilt  output  4  {x_pos, x_neg, y_pos, y_neg}.
- frame_err  output  1  one-cycle pulse on malformed or aborted frame.
- err_count  output  8  saturating count of frame_err pulses.
- busy  output  1  high while a frame is partially received or being drained.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - All outputs go to 0, state IDLE/COLLECT with idx=0, accumulators and frame counter cleared.
  - Any partial frame or partial average is discarded.
- Byte order: idx 0..5 = X0, X1, Y0, Y1, Z0, Z1. Little-endian: axis = {byte(idx odd), byte(idx even)}.
- State COLLECT:
  - Each byte_valid stores the byte into shadow register [idx] and increments idx.
  - busy = (idx != 0).
- byte_last with idx<5: frame_err pulse, frame dropped, idx=0, stay COLLECT.
- Byte at idx=5 with byte_last=1: frame complete; go to the accumulate step and set idx=0.
- Byte at idx=5 with byte_last=0:
  - frame_err pulse, frame dropped, enter DRAIN.
  - DRAIN ignores bytes until a byte with byte_last=1 is accepted, then returns to COLLECT with idx=0.
  - busy=1 throughout DRAIN.
- frame_abort:
  - If idx!=0 or in DRAIN: frame_err pulse, idx=0, go to COLLECT.
  - In COLLECT with idx=0: no effect.
  - Abort has priority over a simultaneous byte_valid; that byte is dropped.
- Accumulate step, same edge as the final byte:
  - Per axis, acc (19-bit signed) += sign-extended raw.
  - frm_cnt (3-bit) increments.
  - When frm_cnt == 2^AVG_LOG2-1 before the increment:
    - accel_* <= (acc + raw) >>> AVG_LOG2, i.e. arithmetic shift, rounding toward -infinity, low 16 bits kept.
    - acc and frm_cnt are cleared.
    - sample_valid=1 for exactly one cycle.
  - Otherwise no output change.
- Latency: accel_*, tilt and sample_valid become visible the cycle after the edge that accepted the completing byte. Outputs hold between updates.
- tilt is registered with accel_* from the new values:
  - x_pos = accel_x > DEADBAND; x_neg = accel_x < -DEADBAND.
  - Y likewise.
  - Values equal to ±DEADBAND give 0.
- err_count increments on every frame_err pulse and saturates at 255; it never wraps.
- frame_err and sample_valid cannot assert in the same cycle.
- byte_valid may be asserted on consecutive cycles. Input has no backpressure; the block accepts every byte.

Test Plan:
1. AVG_LOG2=0: bytes 34,12,CD,AB,00,01 (last on 6th) -> next cycle sample_valid=1 for one cycle, accel_x=0x1234, accel_y=0xABCD, accel_z=0x0100, tilt=4'b1001, frame_err=0.
2. AVG_LOG2=2: four good frames with X = -1,-1,-1,0 (Y,Z=0) -> no sample_valid for frames 1-3; after frame 4 accel_x=0xFFFF (-3>>>2=-1), tilt=0. Then four frames X=100,200,-300,400 -> accel_x=100, x_pos=1.
3. byte_last on 3rd byte -> frame_err pulse, err_count=1, busy drops to 0, no sample_valid. Following good frame updates outputs normally.
4. 8-byte read, last on 8th -> frame_err at 6th byte, bytes 7-8 ignored (busy=1), no sample_valid. Next 6-byte frame accepted and correct.
5. frame_abort coincident with 2nd byte -> frame_err pulse, idx=0, the byte is not stored. frame_abort while idle -> no frame_err, err_count unchanged.
6. reset_n=0 mid-frame and after 2 of 4 averaged frames -> all outputs 0. The next 4 complete frames produce exactly one sample_valid with their own average. Also 300 consecutive short frames -> err_count=255.
